// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic tile sequencer.
// Optional build macro used by the top: SEQ_PERF_CNT_EN (adds perf_cycles output).
package systolic_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } seq_state_t;

   // Width helper: $clog2 but never below one bit, so degenerate sizes still give a usable port.
   function automatic int clog2_min1(input int value);
      int r;
      r = $clog2(value);
      return (r < 1) ? 1 : r;
   endfunction

   // Cycles the skew pipelines need to empty after the last base step: 2N-1.
   function automatic int drain_cycles(input int n);
      return 2 * n - 1;
   endfunction

   localparam int DRAIN_CYC_N4 = drain_cycles(4);

endpackage

// File: rtl/skew_pipe.sv
// Fixed-depth delay line used to skew operand lanes and PE init pulses.
// DEPTH = 0 collapses to a plain wire; otherwise DEPTH registers, cleared synchronously by rst.
module skew_pipe
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign dout = din;
      end else begin : g_regs
         logic [WIDTH-1:0] stages [DEPTH];

         // Shift register: stage 0 captures the input, each later stage takes its predecessor.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int d = 0; d < DEPTH; d++) stages[d] <= '0;
            end else begin
               stages[0] <= din;
               for (int d = 1; d < DEPTH; d++) stages[d] <= stages[d-1];
            end
         end

         assign dout = stages[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Operand-issue and PE-control sequencer for an NxN output-stationary systolic array.
// Walks output tiles (tr outer, tc inner, k innermost), skews A/B bank reads per lane
// and emits per-PE accumulator-clear pulses aligned to each tile's first operand.
// Optional build macro: SEQ_PERF_CNT_EN adds a 32-bit busy-cycle counter output perf_cycles.
module systolic_tile_sequencer
   import systolic_pkg::*;
#(
   parameter int N      = 4,
   parameter int M_ROWS = 8,
   parameter int K_DIM  = 8,
   parameter int P_COLS = 8,
   parameter int A_AW   = clog2_min1((M_ROWS / N) * K_DIM),
   parameter int B_AW   = clog2_min1((P_COLS / N) * K_DIM)
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic [N-1:0]                 rd_en_a,
   output logic [N*A_AW-1:0]            rd_addr_a,
   output logic [N-1:0]                 rd_en_b,
   output logic [N*B_AW-1:0]            rd_addr_b,
   output logic [N*N-1:0]               init_pe,
   output logic [$clog2(M_ROWS/N):0]    tile_row,
   output logic [$clog2(P_COLS/N):0]    tile_col
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]                  perf_cycles
`endif
);

   localparam int TILES_R   = M_ROWS / N;
   localparam int TILES_C   = P_COLS / N;
   localparam int TRW       = $clog2(TILES_R) + 1;
   localparam int TCW       = $clog2(TILES_C) + 1;
   localparam int KW        = clog2_min1(K_DIM);
   localparam int DRAIN_CYC = drain_cycles(N);
   localparam int DCW       = clog2_min1(DRAIN_CYC);

   generate
      if (M_ROWS % N != 0) begin : g_bad_m
         $error("systolic_tile_sequencer: M_ROWS must be a multiple of N");
      end
      if (P_COLS % N != 0) begin : g_bad_p
         $error("systolic_tile_sequencer: P_COLS must be a multiple of N");
      end
      if (K_DIM < 1) begin : g_bad_k
         $error("systolic_tile_sequencer: K_DIM must be at least 1");
      end
   endgenerate

   seq_state_t       state;
   logic [KW-1:0]    k;
   logic [TCW-1:0]   tc;
   logic [TRW-1:0]   tr;
   logic [DCW-1:0]   drain_cnt;

   logic             base_en;
   logic             base_init;
   logic             k_last;
   logic             tc_last;
   logic             tr_last;
   logic [A_AW-1:0]  base_addr_a;
   logic [B_AW-1:0]  base_addr_b;

   // Base-stream step decode: one step per RUN cycle, addresses forced to 0 when no step is live.
   always_comb begin
      base_en     = (state == S_RUN);
      k_last      = (int'(k)  == K_DIM - 1);
      tc_last     = (int'(tc) == TILES_C - 1);
      tr_last     = (int'(tr) == TILES_R - 1);
      base_addr_a = '0;
      base_addr_b = '0;
      if (base_en) begin
         base_addr_a = A_AW'(int'(tr) * K_DIM + int'(k));
         base_addr_b = B_AW'(int'(tc) * K_DIM + int'(k));
      end
      base_init   = base_en && (k == '0);
   end

   // Sequencer FSM and tile/k counters; counters hold through DRAIN and clear on return to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         k         <= '0;
         tc        <= '0;
         tr        <= '0;
         drain_cnt <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) state <= S_RUN;
            end
            S_RUN: begin
               if (k_last && tc_last && tr_last) begin
                  state     <= S_DRAIN;
                  drain_cnt <= '0;
               end else if (k_last) begin
                  k <= '0;
                  if (tc_last) begin
                     tc <= '0;
                     tr <= tr + TRW'(1);
                  end else begin
                     tc <= tc + TCW'(1);
                  end
               end else begin
                  k <= k + KW'(1);
               end
            end
            S_DRAIN: begin
               if (int'(drain_cnt) == DRAIN_CYC - 1) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
                  k     <= '0;
                  tc    <= '0;
                  tr    <= '0;
               end else begin
                  drain_cnt <= drain_cnt + DCW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy     = (state != S_IDLE);
   assign tile_row = tr;
   assign tile_col = tc;

   // Per-lane operand skew and per-PE init skew; lane i is delayed i cycles, PE(i,j) init i+j+1.
   generate
      for (genvar i = 0; i < N; i++) begin : g_lane
         logic [A_AW:0] a_out;
         logic [B_AW:0] b_out;

         skew_pipe #(.WIDTH(A_AW + 1), .DEPTH(i)) u_pipe_a (
            .clk  (clk),
            .rst  (rst),
            .din  ({base_en, base_addr_a}),
            .dout (a_out)
         );

         skew_pipe #(.WIDTH(B_AW + 1), .DEPTH(i)) u_pipe_b (
            .clk  (clk),
            .rst  (rst),
            .din  ({base_en, base_addr_b}),
            .dout (b_out)
         );

         assign rd_en_a[i]                 = a_out[A_AW];
         assign rd_addr_a[i*A_AW +: A_AW]  = a_out[A_AW-1:0];
         assign rd_en_b[i]                 = b_out[B_AW];
         assign rd_addr_b[i*B_AW +: B_AW]  = b_out[B_AW-1:0];

         for (genvar j = 0; j < N; j++) begin : g_pe
            skew_pipe #(.WIDTH(1), .DEPTH(i + j + 1)) u_pipe_init (
               .clk  (clk),
               .rst  (rst),
               .din  (base_init),
               .dout (init_pe[i*N + j])
            );
         end
      end
   endgenerate

`ifdef SEQ_PERF_CNT_EN
   // Busy-cycle counter: cleared when a start is accepted, counts RUN+DRAIN, then holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles <= '0;
      end else if ((state == S_IDLE) && start) begin
         perf_cycles <= '0;
      end else if (busy) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`else
`endif

endmodule
